instr_prefetch_queue: RTL and testbench

Fetch-side prefetch buffer between a handshaked, variable-latency instruction memory port and the CPU's IF/ID register. It issues sequential 32-bit fetch requests and tracks the requests still in flight. Returned instructions are queued with their PCs and handed downstream through a valid/ready interface. On a redirect (taken branch, jal, jalr) it flushes the queue and discards stale in-flight responses.

---
 rtl/instr_prefetch_queue.sv | 88 ++++++++
 tb/tb_instr_prefetch_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction prefetch queue with in-flight tracking and redirect flush; ports clk_i/rst_i, start_i, redirect_i/redirect_pc_i, mem_req_o/mem_addr_o/mem_gnt_i, mem_rvalid_i/mem_rdata_i, inst_valid_o/inst_o/pc_o/deq_ready_i; optional PREFETCH_BYPASS_EN forwards a response straight to the head outputs when the queue is empty
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        deq_ready_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, resp_pc, target_pc;
  logic [CW-1:0] count, outstanding, discard;
  logic [PW-1:0] head, tail;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [CW:0] inflight;
  logic grant, drop, bypass, accept, push, pop;
  assign target_pc = redirect_pc_i & ~32'h3;
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_o = (state == RUN) & ~redirect_i & (inflight < DEPTH_W);
  assign mem_addr_o = fetch_pc;
  assign grant = mem_req_o & mem_gnt_i;
  assign drop = discard != '0;
`ifdef PREFETCH_BYPASS_EN
  assign bypass = (count == '0) & ~drop & mem_rvalid_i & ~redirect_i;
`else
  assign bypass = 1'b0;
`endif
  assign inst_valid_o = (count != '0) | bypass;
  assign inst_o = bypass ? mem_rdata_i : inst_mem[head];
  assign pc_o = bypass ? resp_pc : pc_mem[head];
  assign pop = (count != '0) & deq_ready_i & ~redirect_i;
  assign accept = mem_rvalid_i & ~drop & ~redirect_i;
  // a bypassed response taken by the consumer never occupies an entry
  assign push = accept & ~(bypass & deq_ready_i);
  always_comb state_nx = (state == IDLE && start_i && !redirect_i) ? RUN : state;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_i) begin
      fetch_pc <= target_pc;
      resp_pc <= target_pc;
      count <= '0;
      head <= '0;
      tail <= '0;
      outstanding <= outstanding - CW'(mem_rvalid_i);
      // outstanding already includes responses marked for discard, so every
      // response still in flight after this edge is stale
      discard <= (outstanding == '0) ? '0 : outstanding - CW'(mem_rvalid_i);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid_i);
      if (mem_rvalid_i && drop) discard <= discard - 1'b1;
      if (accept) resp_pc <= resp_pc + 32'd4;
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) begin
      inst_mem[tail] <= mem_rdata_i;
      pc_mem[tail] <= resp_pc;
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: randomized bench with a memory model and a queue-level reference of the prefetch buffer
module tb_instr_prefetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst, start, redirect, mem_req, mem_gnt, mem_rvalid, inst_valid, deq_ready;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, inst, pc;
  always #5 clk = ~clk;
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .inst_valid_o(inst_valid), .inst_o(inst), .pc_o(pc), .deq_ready_i(deq_ready)
  );
  typedef struct {logic [31:0] addr; int ready; bit stale;} req_t;
  req_t pend[$];
  logic [63:0] q[$];
  logic [31:0] m_fetch, m_resp;
  bit m_run;
  int cyc = 0, last_ready = 0, cur_lat = 1;
  int total = 0, bad = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit byp_now();
`ifdef PREFETCH_BYPASS_EN
    return q.size() == 0 && mem_rvalid && !redirect && pend.size() > 0 && !pend[0].stale;
`else
    return 1'b0;
`endif
  endfunction
  task automatic mem_drive();
    mem_rvalid = pend.size() > 0 && pend[0].ready <= cyc;
    mem_rdata = mem_rvalid ? mem_word(pend[0].addr) : $urandom;
  endtask
  task automatic step();
    bit exp_req, byp, ev, rv;
    logic [63:0] hd;
    req_t r;
    @(negedge clk);
    exp_req = m_run && !redirect && (q.size() + pend.size() < DEPTH);
    chk("req", mem_req, exp_req);
    chk("addr", mem_addr, m_fetch);
    byp = byp_now();
    ev = q.size() != 0 || byp;
    chk("valid", inst_valid, ev);
    if (ev) begin
      hd = q.size() != 0 ? q[0] : {m_resp, mem_rdata};
      chk("pc", pc, hd[63:32]);
      chk("inst", inst, hd[31:0]);
    end
    @(posedge clk);
    rv = mem_rvalid;
    if (rv) r = pend.pop_front();
    if (redirect) begin
      foreach (pend[i]) pend[i].stale = 1;
      q.delete();
      m_fetch = redirect_pc & ~32'h3;
      m_resp = m_fetch;
    end else begin
      if (q.size() > 0 && deq_ready) void'(q.pop_front());
      if (rv && !r.stale) begin
        if (!(byp && deq_ready)) begin
          chk("push_full", 32'(q.size() < DEPTH), 1);
          q.push_back({m_resp, mem_rdata});
        end
        m_resp += 4;
      end
      if (exp_req && mem_gnt) begin
        last_ready = (cyc + cur_lat > last_ready + 1) ? cyc + cur_lat : last_ready + 1;
        pend.push_back('{m_fetch, last_ready, 1'b0});
        m_fetch += 4;
      end
      if (!m_run && start) m_run = 1;
    end
    if (q.size() + pend.size() > DEPTH) chk("credit", 32'(q.size() + pend.size()), DEPTH);
    cyc++;
    #1;
  endtask
  task automatic cyc_go(input bit s, g, d, r, input logic [31:0] rpc, input int lat);
    mem_drive();
    start = s;
    mem_gnt = g;
    deq_ready = d;
    redirect = r;
    redirect_pc = rpc;
    cur_lat = lat;
    step();
  endtask
  task automatic rand_go(input int gp, dp, rpm);
    cyc_go(1, $urandom_range(99) < gp, $urandom_range(99) < dp, $urandom_range(999) < rpm,
           $urandom, $urandom_range(1, 4));
  endtask
  task automatic do_rst();
    rst = 1;
    start = 0;
    redirect = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    deq_ready = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_addr", mem_addr, 0);
    pend.delete();
    q.delete();
    m_fetch = 0;
    m_resp = 0;
    m_run = 0;
    last_ready = cyc;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    redirect_pc = 0;
    mem_rdata = 0;
    do_rst();
    for (int i = 0; i < 20; i++) cyc_go(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) cyc_go(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc_go(1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc_go(1, 1, 1, 0, 0, 3);
    cyc_go(1, 1, 1, 1, 32'h103, 3);
    for (int i = 0; i < 12; i++) cyc_go(1, 1, 1, 0, 0, 2);
    for (int i = 0; i < 5; i++) cyc_go(1, 0, 1, 0, 0, 2);
    cyc_go(1, 1, 1, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 8; i++) cyc_go(1, 1, $urandom_range(1), 0, 0, 1);
    for (int i = 0; i < 1500; i++) rand_go(70, 60, 30);
    for (int i = 0; i < 7; i++) cyc_go(1, 1, 1, 0, 0, 3);
    do_rst();
    cyc_go(0, 1, 1, 1, 32'h0000_0042, 1);
    for (int i = 0; i < 3; i++) cyc_go(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 1500; i++) rand_go(80, 50, 60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
